alu_brc: RTL and testbench

ALU_BRC -- requirements
Module: alu_brc

---
 rtl/alu_brc.sv | 159 +++++++++++++++
 tb/tb_alu_brc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_brc.sv
// Branch-resolution unit: resolves a branch from comparator flags into taken/next_pc behind a 2-entry skid buffer.
// Optional taken/not-taken delivery counters are built when ALU_BRC_STATS_EN is defined.
module alu_brc #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  cond,
  input  logic        src_equ,
  input  logic        src_neq,
  input  logic        src_lth,
  input  logic        src_lte,
  input  logic        src_gth,
  input  logic        src_gte,
  input  logic [31:0] pc,
  input  logic [31:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        taken,
  output logic [31:0] next_pc,
  output logic        flag_err
`ifdef ALU_BRC_STATS_EN
  ,
  input  logic        cnt_clr,
  output logic [15:0] cnt_taken,
  output logic [15:0] cnt_ntaken
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_out_taken;
  logic [31:0] r_out_next_pc;
  logic        r_out_err;
  logic        r_skid_taken;
  logic [31:0] r_skid_next_pc;
  logic        r_skid_err;

  logic        w_accept;
  logic        w_deliver;
  logic        w_err;
  logic        w_sel;
  logic        w_taken;
  logic [31:0] w_next_pc;

  assign w_accept  = in_valid & r_in_ready;
  assign w_deliver = r_out_valid & out_ready;

  // The result is resolved at acceptance, so only the decision is buffered.
  always_comb begin
    w_err = (src_neq != ~src_equ) |
            (src_lte != (src_lth | src_equ)) |
            (src_gth != ~src_lte) |
            (src_gte != ~src_lth);
    w_sel = 1'b0;
    case (cond)
      3'b000:  w_sel = src_equ;
      3'b001:  w_sel = src_neq;
      3'b010:  w_sel = src_lth;
      3'b011:  w_sel = src_lte;
      3'b100:  w_sel = src_gth;
      3'b101:  w_sel = src_gte;
      3'b110:  w_sel = 1'b1;
      default: w_sel = 1'b0;
    endcase
    w_taken   = w_sel & ~w_err;
    w_next_pc = w_taken ? target : (pc + PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= EMPTY;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_taken    <= 1'b0;
      r_out_next_pc  <= 32'h0;
      r_out_err      <= 1'b0;
      r_skid_taken   <= 1'b0;
      r_skid_next_pc <= 32'h0;
      r_skid_err     <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_out_taken   <= w_taken;
            r_out_next_pc <= w_next_pc;
            r_out_err     <= w_err;
            r_out_valid   <= 1'b1;
            r_state       <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_deliver) begin
            r_out_taken   <= w_taken;
            r_out_next_pc <= w_next_pc;
            r_out_err     <= w_err;
          end else if (w_accept) begin
            r_skid_taken   <= w_taken;
            r_skid_next_pc <= w_next_pc;
            r_skid_err     <= w_err;
            r_in_ready     <= 1'b0;
            r_state        <= TWO;
          end else if (w_deliver) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          // The skid entry is older than anything still upstream, so it moves up first.
          if (w_deliver) begin
            r_out_taken   <= r_skid_taken;
            r_out_next_pc <= r_skid_next_pc;
            r_out_err     <= r_skid_err;
            r_in_ready    <= 1'b1;
            r_state       <= ONE;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign taken     = r_out_taken;
  assign next_pc   = r_out_next_pc;
  assign flag_err  = r_out_err;

`ifdef ALU_BRC_STATS_EN
  logic [15:0] r_cnt_taken;
  logic [15:0] r_cnt_ntaken;

  // Clear wins over a same-cycle delivery; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt_taken  <= 16'h0;
      r_cnt_ntaken <= 16'h0;
    end else if (w_deliver) begin
      if (r_out_taken && (r_cnt_taken != 16'hFFFF))
        r_cnt_taken <= r_cnt_taken + 16'd1;
      if (!r_out_taken && (r_cnt_ntaken != 16'hFFFF))
        r_cnt_ntaken <= r_cnt_ntaken + 16'd1;
    end
  end

  assign cnt_taken  = r_cnt_taken;
  assign cnt_ntaken = r_cnt_ntaken;
`endif

endmodule

// File: tb/tb_alu_brc.sv
// Directed testbench for alu_brc: vector table for branch resolution plus skid, reset and counter sequences.
// Counter sequences are built only when ALU_BRC_STATS_EN is defined.
module tb_alu_brc;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [2:0]  cond;
  logic        srcEqu, srcNeq, srcLth, srcLte, srcGth, srcGte;
  logic [31:0] pc;
  logic [31:0] target;
  logic        outValid;
  logic        outReady;
  logic        taken;
  logic [31:0] nextPc;
  logic        flagErr;
`ifdef ALU_BRC_STATS_EN
  logic        cntClr;
  logic [15:0] cntTaken;
  logic [15:0] cntNtaken;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  alu_brc #(.PC_STEP(32'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .cond      (cond),
    .src_equ   (srcEqu),
    .src_neq   (srcNeq),
    .src_lth   (srcLth),
    .src_lte   (srcLte),
    .src_gth   (srcGth),
    .src_gte   (srcGte),
    .pc        (pc),
    .target    (target),
    .out_valid (outValid),
    .out_ready (outReady),
    .taken     (taken),
    .next_pc   (nextPc),
    .flag_err  (flagErr)
`ifdef ALU_BRC_STATS_EN
    ,
    .cnt_clr   (cntClr),
    .cnt_taken (cntTaken),
    .cnt_ntaken(cntNtaken)
`endif
  );

  // Flag packing is {equ, neq, lth, lte, gth, gte}.
  localparam logic [5:0] FLT  = 6'b011100;
  localparam logic [5:0] FEQ  = 6'b100101;
  localparam logic [5:0] FGT  = 6'b010011;
  localparam logic [5:0] FBAD = 6'b110101;
  localparam logic [5:0] FBD2 = 6'b011110;

  typedef struct {
    logic [2:0]  cond;
    logic [5:0]  flags;
    logic [31:0] pc;
    logic [31:0] target;
    logic        expTaken;
    logic [31:0] expNextPc;
    logic        expErr;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [5:0] f,
                               input logic [31:0] p, input logic [31:0] t);
    inValid = v;
    cond    = c;
    {srcEqu, srcNeq, srcLth, srcLte, srcGth, srcGte} = f;
    pc      = p;
    target  = t;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  initial begin
    vecs[0]  = '{3'b010, FLT,  32'h0000_0100, 32'h0000_0200, 1'b1, 32'h0000_0200, 1'b0};
    vecs[1]  = '{3'b110, FBAD, 32'h0000_1000, 32'h0000_2000, 1'b0, 32'h0000_1004, 1'b1};
    vecs[2]  = '{3'b111, FLT,  32'hFFFF_FFFC, 32'h0000_0300, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{3'b000, FEQ,  32'h0000_0040, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0};
    vecs[4]  = '{3'b000, FGT,  32'h0000_0040, 32'h0000_0080, 1'b0, 32'h0000_0044, 1'b0};
    vecs[5]  = '{3'b001, FGT,  32'h0000_0500, 32'h0000_0600, 1'b1, 32'h0000_0600, 1'b0};
    vecs[6]  = '{3'b011, FEQ,  32'h0000_0700, 32'h0000_0800, 1'b1, 32'h0000_0800, 1'b0};
    vecs[7]  = '{3'b100, FLT,  32'h0000_0900, 32'h0000_0A00, 1'b0, 32'h0000_0904, 1'b0};
    vecs[8]  = '{3'b101, FEQ,  32'h0000_0B00, 32'h0000_0C00, 1'b1, 32'h0000_0C00, 1'b0};
    vecs[9]  = '{3'b100, FGT,  32'h0000_0D00, 32'h0000_0E00, 1'b1, 32'h0000_0E00, 1'b0};
    vecs[10] = '{3'b110, FEQ,  32'h1234_5678, 32'hCAFE_0000, 1'b1, 32'hCAFE_0000, 1'b0};
    vecs[11] = '{3'b011, FGT,  32'h0000_0F00, 32'h0000_1F00, 1'b0, 32'h0000_0F04, 1'b0};
    vecs[12] = '{3'b110, FBD2, 32'h0000_2000, 32'h0000_3000, 1'b0, 32'h0000_2004, 1'b1};
    vecs[13] = '{3'b110, FBD2, 32'hFFFF_FFFC, 32'h0000_4000, 1'b0, 32'h0000_0000, 1'b1};

    rst = 1'b1;
    outReady = 1'b0;
    applyStimulus(1'b0, 3'b000, FEQ, 32'h0, 32'h0);
`ifdef ALU_BRC_STATS_EN
    cntClr = 1'b0;
`endif
    step();
    step();
    checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset in_ready",  {31'b0, inReady},  32'd1);
    checkOutput("reset taken",     {31'b0, taken},    32'd0);
    checkOutput("reset next_pc",   nextPc,            32'h0);
    checkOutput("reset flag_err",  {31'b0, flagErr},  32'd0);

    // The first request lands in the first cycle after reset is released.
    rst = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, vecs[i].cond, vecs[i].flags, vecs[i].pc, vecs[i].target);
      step();
      applyStimulus(1'b0, 3'b000, FEQ, 32'h0, 32'h0);
      checkOutput($sformatf("vec%0d out_valid", i), {31'b0, outValid}, 32'd1);
      checkOutput($sformatf("vec%0d taken", i),     {31'b0, taken},    {31'b0, vecs[i].expTaken});
      checkOutput($sformatf("vec%0d next_pc", i),   nextPc,            vecs[i].expNextPc);
      checkOutput($sformatf("vec%0d flag_err", i),  {31'b0, flagErr},  {31'b0, vecs[i].expErr});
      step();
      checkOutput($sformatf("vec%0d drained", i),   {31'b0, outValid}, 32'd0);
    end

    // Three back-to-back requests against a stalled output.
    outReady = 1'b0;
    applyStimulus(1'b1, 3'b110, FEQ, 32'h0000_0A00, 32'h0000_AA00);
    step();
    checkOutput("bb in_ready after 1st", {31'b0, inReady}, 32'd1);
    applyStimulus(1'b1, 3'b111, FEQ, 32'h0000_0B00, 32'h0000_BB00);
    step();
    checkOutput("bb in_ready after 2nd", {31'b0, inReady}, 32'd0);
    checkOutput("bb head next_pc",       nextPc,           32'h0000_AA00);
    applyStimulus(1'b1, 3'b110, FEQ, 32'h0000_0C00, 32'h0000_CC00);
    step();
    checkOutput("bb stall in_ready", {31'b0, inReady},  32'd0);
    checkOutput("bb stall next_pc",  nextPc,            32'h0000_AA00);
    checkOutput("bb stall taken",    {31'b0, taken},    32'd1);
    checkOutput("bb stall valid",    {31'b0, outValid}, 32'd1);
    outReady = 1'b1;
    step();
    checkOutput("bb 2nd next_pc",  nextPc,           32'h0000_0B04);
    checkOutput("bb 2nd taken",    {31'b0, taken},   32'd0);
    checkOutput("bb ready again",  {31'b0, inReady}, 32'd1);
    step();
    applyStimulus(1'b0, 3'b000, FEQ, 32'h0, 32'h0);
    checkOutput("bb 3rd next_pc", nextPc,            32'h0000_CC00);
    checkOutput("bb 3rd valid",   {31'b0, outValid}, 32'd1);
    step();
    checkOutput("bb empty", {31'b0, outValid}, 32'd0);

    // Reset while both entries are held; a request during reset must be dropped.
    outReady = 1'b0;
    applyStimulus(1'b1, 3'b110, FEQ, 32'h0, 32'h0000_D000);
    step();
    applyStimulus(1'b1, 3'b110, FEQ, 32'h0, 32'h0000_E000);
    step();
    checkOutput("rst2 pre in_ready", {31'b0, inReady}, 32'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 3'b110, FEQ, 32'h0, 32'h0000_F000);
    step();
    checkOutput("rst2 out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("rst2 in_ready",  {31'b0, inReady},  32'd1);
    checkOutput("rst2 next_pc",   nextPc,            32'h0);
    rst = 1'b0;
    outReady = 1'b1;
    applyStimulus(1'b0, 3'b000, FEQ, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("rst2 no stale %0d", i), {31'b0, outValid}, 32'd0);
    end

`ifdef ALU_BRC_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("cnt reset taken",  {16'b0, cntTaken},  32'd0);
    checkOutput("cnt reset ntaken", {16'b0, cntNtaken}, 32'd0);
    outReady = 1'b1;
    applyStimulus(1'b1, 3'b110, FEQ, 32'h0, 32'h0000_1000);
    repeat (32'h10000) step();
    checkOutput("cnt 0xFFFF deliveries", {16'b0, cntTaken}, 32'h0000_FFFF);
    step();
    checkOutput("cnt saturated",  {16'b0, cntTaken},  32'h0000_FFFF);
    checkOutput("cnt ntaken idle", {16'b0, cntNtaken}, 32'd0);
    cntClr = 1'b1;
    step();
    cntClr = 1'b0;
    checkOutput("cnt clr over delivery", {16'b0, cntTaken}, 32'd0);
    applyStimulus(1'b1, 3'b111, FEQ, 32'h0, 32'h0000_1000);
    step();
    applyStimulus(1'b0, 3'b000, FEQ, 32'h0, 32'h0);
    checkOutput("cnt after clr", {16'b0, cntTaken}, 32'd1);
    step();
    checkOutput("cnt ntaken one", {16'b0, cntNtaken}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
